// File: rtl/rx_frame_stager.sv
// rx_frame_stager: store-and-forward stage in front of the AXI write DMA.
// Buffers whole AXI-stream frames, pairs each one with a host buffer
// address, issues one (address, byte count) command and then streams the
// frame. It reports each frame once its last beat has been handed over.
// Optional feature: define RX_STAGER_DROP_OVERSIZE_EN to drop frames larger
// than MAX_FRAME_BYTES and expose a saturating drop_count output.
module rx_frame_stager #(
  parameter int ADDRESS_BITS    = 32,
  parameter int LENGTH_BITS     = 32,
  parameter int DATA_DEPTH_LOG2 = 9,
  parameter int LEN_DEPTH_LOG2  = 4
`ifdef RX_STAGER_DROP_OVERSIZE_EN
  ,
  parameter int MAX_FRAME_BYTES = 1522
`endif
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [31:0]             s_tdata,
  input  logic [3:0]              s_tkeep,
  input  logic                    s_tlast,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic [ADDRESS_BITS-1:0] buf_address,
  input  logic                    buf_valid,
  output logic                    buf_ready,
  output logic [ADDRESS_BITS-1:0] cmd_address,
  output logic [LENGTH_BITS-1:0]  cmd_bytes,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [31:0]             dout_tdata,
  output logic [3:0]              dout_tkeep,
  output logic                    dout_tlast,
  output logic                    dout_tvalid,
  input  logic                    dout_tready,
  output logic [LENGTH_BITS-1:0]  stat_bytes,
  output logic                    stat_valid
`ifdef RX_STAGER_DROP_OVERSIZE_EN
  ,
  output logic [15:0]             drop_count
`endif
);

  // Pointers carry one extra MSB so that full and empty can be told apart.
  localparam int DPW = DATA_DEPTH_LOG2 + 1;
  localparam int LPW = LEN_DEPTH_LOG2 + 1;
  localparam logic [DPW-1:0] DataDepth = DPW'(2 ** DATA_DEPTH_LOG2);
  localparam logic [LPW-1:0] LenDepth  = LPW'(2 ** LEN_DEPTH_LOG2);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_e;

  logic [35:0]            dataMem [2 ** DATA_DEPTH_LOG2];
  logic [LENGTH_BITS-1:0] lenMem  [2 ** LEN_DEPTH_LOG2];

  logic [DPW-1:0]         wrPtr_q, wrPtr_d;
  logic [DPW-1:0]         wrCommit_q, wrCommit_d;
  logic [DPW-1:0]         rdPtr_q;
  logic [LPW-1:0]         lenWr_q, lenRd_q;
  logic [LENGTH_BITS-1:0] acc_q, acc_d;
  logic [LENGTH_BITS-1:0] total;
  logic [2:0]             keepCount;
  logic                   readyEn_q;
  logic                   wrFire, memWrite, lenPush, lenPop;
  logic                   dataFull, lenFull, lenEmpty;
  logic                   frameBad;

  state_e                 state_q, state_d;
  logic [ADDRESS_BITS-1:0] cmdAddress_q;
  logic [LENGTH_BITS-1:0] cmdBytes_q;
  logic [LENGTH_BITS-1:0] beat_q;
  logic                   gap_q;
  logic                   latchCmd, beatAdvance, lastBeat;
  logic [LENGTH_BITS-1:0] lenHead;

  // ---------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------

  // Occupancy is measured against wrPtr (not wrCommit) so that a frame
  // still being received can never overwrite unread data.
  assign dataFull  = (DPW'(wrPtr_q - rdPtr_q) == DataDepth);
  assign lenFull   = (LPW'(lenWr_q - lenRd_q) == LenDepth);
  assign lenEmpty  = (lenWr_q == lenRd_q);
  assign keepCount = {2'b00, s_tkeep[0]} + {2'b00, s_tkeep[1]}
                   + {2'b00, s_tkeep[2]} + {2'b00, s_tkeep[3]};
  assign total     = acc_q + LENGTH_BITS'(keepCount);
  assign wrFire    = s_tvalid && s_tready;
  assign lenHead   = lenMem[lenRd_q[LEN_DEPTH_LOG2-1:0]];

`ifdef RX_STAGER_DROP_OVERSIZE_EN
  logic        bad_q;
  logic [15:0] dropCount_q;

  // A frame turns bad on the first beat that takes it past the limit and
  // stays bad (drained, never written) until its tlast.
  assign frameBad   = bad_q || (total > LENGTH_BITS'(MAX_FRAME_BYTES));
  assign s_tready   = readyEn_q && (bad_q || (!dataFull && !lenFull));
  assign drop_count = dropCount_q;

  // Oversize tracking and the saturating dropped-frame counter.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bad_q       <= 1'b0;
      dropCount_q <= 16'd0;
    end else if (wrFire) begin
      bad_q <= s_tlast ? 1'b0 : frameBad;
      if (s_tlast && frameBad && (dropCount_q != 16'hFFFF)) begin
        dropCount_q <= dropCount_q + 16'd1;
      end
    end
  end
`else
  assign frameBad = 1'b0;
  assign s_tready = readyEn_q && !dataFull && !lenFull;
`endif

  // Next-state for the write pointer, commit point and byte accumulator:
  // a frame becomes visible to the reader only when its tlast commits it.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    wrCommit_d = wrCommit_q;
    acc_d      = acc_q;
    memWrite   = 1'b0;
    lenPush    = 1'b0;
    if (wrFire) begin
      if (!frameBad) begin
        memWrite = 1'b1;
        wrPtr_d  = wrPtr_q + DPW'(1);
      end
      if (s_tlast) begin
        acc_d = '0;
        if (!frameBad && (total != '0)) begin
          wrCommit_d = wrPtr_q + DPW'(1);
          lenPush    = 1'b1;
        end else begin
          wrPtr_d = wrCommit_q;
        end
      end else begin
        acc_d = total;
      end
    end
  end

  // Write-side registers; readyEn_q keeps s_tready low while in reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wrPtr_q    <= '0;
      wrCommit_q <= '0;
      acc_q      <= '0;
      lenWr_q    <= '0;
      readyEn_q  <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      wrCommit_q <= wrCommit_d;
      acc_q      <= acc_d;
      readyEn_q  <= 1'b1;
      if (lenPush) begin
        lenWr_q <= lenWr_q + LPW'(1);
      end
    end
  end

  // Storage arrays: beat data with its keep, and committed frame lengths.
  always_ff @(posedge aclk) begin
    if (memWrite) begin
      dataMem[wrPtr_q[DATA_DEPTH_LOG2-1:0]] <= {s_tkeep, s_tdata};
    end
    if (lenPush) begin
      lenMem[lenWr_q[LEN_DEPTH_LOG2-1:0]] <= total;
    end
  end

  // ---------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------

  assign lastBeat    = (beat_q == ((cmdBytes_q - LENGTH_BITS'(1)) >> 2));
  assign cmd_address = cmdAddress_q;
  assign cmd_bytes   = cmdBytes_q;
  assign stat_bytes  = cmdBytes_q;
  assign dout_tdata  = dataMem[rdPtr_q[DATA_DEPTH_LOG2-1:0]][31:0];
  assign dout_tkeep  = dataMem[rdPtr_q[DATA_DEPTH_LOG2-1:0]][35:32];
  assign dout_tlast  = (state_q == S_DATA) && lastBeat;

  // Read FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Read FSM next state and handshake outputs. gap_q holds S_IDLE one extra
  // cycle so the DMA sees at least three quiet cycles between frames.
  always_comb begin
    state_d     = state_q;
    buf_ready   = 1'b0;
    cmd_valid   = 1'b0;
    dout_tvalid = 1'b0;
    stat_valid  = 1'b0;
    latchCmd    = 1'b0;
    beatAdvance = 1'b0;
    lenPop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!gap_q && !lenEmpty && buf_valid) begin
          buf_ready = 1'b1;
          latchCmd  = 1'b1;
          state_d   = S_CMD;
        end
      end
      S_CMD: begin
        cmd_valid = 1'b1;
        if (cmd_ready) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        dout_tvalid = 1'b1;
        if (dout_tready) begin
          beatAdvance = 1'b1;
          if (lastBeat) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        stat_valid = 1'b1;
        lenPop     = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read-side datapath: command latch, beat counter, read pointers, gap.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cmdAddress_q <= '0;
      cmdBytes_q   <= '0;
      beat_q       <= '0;
      rdPtr_q      <= '0;
      lenRd_q      <= '0;
      gap_q        <= 1'b0;
    end else begin
      if (latchCmd) begin
        cmdAddress_q <= buf_address;
        cmdBytes_q   <= lenHead;
        beat_q       <= '0;
      end
      if (beatAdvance) begin
        rdPtr_q <= rdPtr_q + DPW'(1);
        beat_q  <= beat_q + LENGTH_BITS'(1);
      end
      if (lenPop) begin
        lenRd_q <= lenRd_q + LPW'(1);
      end
      if (state_q == S_DONE) begin
        gap_q <= 1'b1;
      end else if (state_q == S_IDLE) begin
        gap_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_stager.sv
// Testbench for rx_frame_stager: table of directed frames plus hand-written
// sequences for held buffer addresses, zero-byte frames, random stalls,
// oversize dropping (when RX_STAGER_DROP_OVERSIZE_EN is defined) and reset
// in the middle of a data burst.
module tb_rx_frame_stager;

  typedef struct {
    int          nBeats;
    logic [3:0]  lastKeep;
    logic [31:0] addr;
    int          expBytes;
    int          expBeats;
  } vecT;

  typedef struct {
    logic [31:0] addr;
    int          bytes;
    int          beats;
    logic [3:0]  lastKeep;
  } frameT;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep;
  logic        s_tlast, s_tvalid, s_tready;
  logic [31:0] buf_address;
  logic        buf_valid, buf_ready;
  logic [31:0] cmd_address, cmd_bytes;
  logic        cmd_valid, cmd_ready;
  logic [31:0] dout_tdata;
  logic [3:0]  dout_tkeep;
  logic        dout_tlast, dout_tvalid, dout_tready;
  logic [31:0] stat_bytes;
  logic        stat_valid;
`ifdef RX_STAGER_DROP_OVERSIZE_EN
  logic [15:0] drop_count;
`endif

  int          compared, mismatched, statCount;
  bit          bufEnable, stallMode;
  frameT       expFrameQ[$];
  logic [36:0] expBeatQ[$];
  logic [36:0] gotBeatQ[$];
  logic [63:0] gotCmdQ[$];
  logic [31:0] gotStatQ[$];
  logic [31:0] bufQ[$];
  vecT         vecs[6];

  rx_frame_stager dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .buf_address(buf_address), .buf_valid(buf_valid), .buf_ready(buf_ready),
    .cmd_address(cmd_address), .cmd_bytes(cmd_bytes),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .dout_tdata(dout_tdata), .dout_tkeep(dout_tkeep), .dout_tlast(dout_tlast),
    .dout_tvalid(dout_tvalid), .dout_tready(dout_tready),
    .stat_bytes(stat_bytes), .stat_valid(stat_valid)
`ifdef RX_STAGER_DROP_OVERSIZE_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 aclk = ~aclk;

  // Monitor and sink: record DMA-side traffic on the falling edge, then
  // after the rising edge update the buffer-address source and ready stalls.
  initial begin
    bit bufTaken;
    buf_valid = 1'b0; buf_address = '0; cmd_ready = 1'b1; dout_tready = 1'b1;
    forever begin
      @(negedge aclk);
      bufTaken = 1'b0;
      if (aresetn) begin
        if (cmd_valid && cmd_ready) gotCmdQ.push_back({cmd_address, cmd_bytes});
        if (dout_tvalid && dout_tready) gotBeatQ.push_back({dout_tlast, dout_tkeep, dout_tdata});
        if (stat_valid) begin
          gotStatQ.push_back(stat_bytes);
          statCount++;
        end
        bufTaken = buf_valid && buf_ready;
      end
      @(posedge aclk); #1;
      if (bufTaken && bufQ.size() > 0) void'(bufQ.pop_front());
      buf_valid   = bufEnable && (bufQ.size() > 0);
      buf_address = (bufQ.size() > 0) ? bufQ[0] : 32'd0;
      if (stallMode) begin
        dout_tready = ($urandom_range(0, 3) != 0);
        cmd_ready   = ($urandom_range(0, 2) == 0);
      end else begin
        dout_tready = 1'b1;
        cmd_ready   = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic failTimeout(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: timed out waiting, got no event, expected one", name);
  endtask

  task automatic checkReset(input string name);
    checkOutput({name, " s_tready"}, s_tready, 0);
    checkOutput({name, " buf_ready"}, buf_ready, 0);
    checkOutput({name, " cmd_valid"}, cmd_valid, 0);
    checkOutput({name, " dout_tvalid"}, dout_tvalid, 0);
    checkOutput({name, " stat_valid"}, stat_valid, 0);
    checkOutput({name, " cmd_address"}, cmd_address, 0);
    checkOutput({name, " cmd_bytes"}, cmd_bytes, 0);
    checkOutput({name, " stat_bytes"}, stat_bytes, 0);
  endtask

  // Drive one frame onto s_*; forwarded frames also feed the beat scoreboard.
  task automatic sendFrame(input int nBeats, input logic [3:0] lastKeep, input bit expectFwd);
    for (int b = 0; b < nBeats; b++) begin
      bit taken = 0;
      int waited = 0;
      s_tdata  = $urandom();
      s_tkeep  = (b == nBeats - 1) ? lastKeep : 4'hF;
      s_tlast  = (b == nBeats - 1);
      s_tvalid = 1'b1;
      while (!taken && waited < 5000) begin
        @(negedge aclk);
        taken = s_tready;
        @(posedge aclk); #1;
        waited++;
      end
      if (!taken) begin
        failTimeout("s_tready");
        break;
      end
      if (expectFwd) expBeatQ.push_back({s_tlast, s_tkeep, s_tdata});
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Queue and send a forwarded frame of a given byte count.
  task automatic queueFrame(input int bytes, input logic [31:0] addr);
    int nb = (bytes + 3) / 4;
    logic [3:0] lk;
    case (bytes % 4)
      1: lk = 4'h1;
      2: lk = 4'h3;
      3: lk = 4'h7;
      default: lk = 4'hF;
    endcase
    expFrameQ.push_back('{addr, bytes, nb, lk});
    bufQ.push_back(addr);
    sendFrame(nb, lk, 1'b1);
  endtask

  task automatic applyStimulus(input vecT v);
    expFrameQ.push_back('{v.addr, v.expBytes, v.expBeats, v.lastKeep});
    bufQ.push_back(v.addr);
    sendFrame(v.nBeats, v.lastKeep, 1'b1);
  endtask

  task automatic waitStats(input int target, input string name);
    int n = 0;
    while (statCount < target && n < 60000) begin
      @(posedge aclk); #1;
      n++;
    end
    if (statCount < target) failTimeout({name, " stat_valid"});
  endtask

  // Compare everything the DUT forwarded against the expected frame list.
  task automatic checkFrames(input string name);
    checkOutput({name, " cmd count"}, gotCmdQ.size(), expFrameQ.size());
    checkOutput({name, " stat count"}, gotStatQ.size(), expFrameQ.size());
    while (expFrameQ.size() > 0 && gotCmdQ.size() > 0 && gotStatQ.size() > 0) begin
      frameT e = expFrameQ.pop_front();
      logic [63:0] c = gotCmdQ.pop_front();
      logic [31:0] st = gotStatQ.pop_front();
      int beats = 0;
      bit dataOk = 1, done = 0;
      logic [3:0] lastKeep = '0;
      checkOutput({name, " cmd_address"}, c[63:32], e.addr);
      checkOutput({name, " cmd_bytes"}, c[31:0], e.bytes);
      checkOutput({name, " stat_bytes"}, st, e.bytes);
      while (!done && gotBeatQ.size() > 0) begin
        logic [36:0] g = gotBeatQ.pop_front();
        beats++;
        if (expBeatQ.size() > 0) begin
          if (g !== expBeatQ.pop_front()) dataOk = 0;
        end else begin
          dataOk = 0;
        end
        lastKeep = g[35:32];
        done = g[36];
      end
      checkOutput({name, " beat count"}, beats, e.beats);
      checkOutput({name, " last tkeep"}, lastKeep, e.lastKeep);
      checkOutput({name, " data"}, dataOk, 1);
    end
    checkOutput({name, " leftover beats"}, gotBeatQ.size(), 0);
    expFrameQ.delete(); expBeatQ.delete(); gotBeatQ.delete();
    gotCmdQ.delete(); gotStatQ.delete();
  endtask

  initial begin
    int n;
    compared = 0; mismatched = 0; statCount = 0;
    bufEnable = 1; stallMode = 0;
    s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
    aresetn = 1'b0;

    // {beats, last tkeep, address, expected bytes, expected dout beats}
    vecs[0] = '{16, 4'hF, 32'h0000_1002, 64, 16};
    vecs[1] = '{16, 4'h1, 32'h0000_2001, 61, 16};
    vecs[2] = '{16, 4'hE, 32'h0000_3003, 63, 16};
    vecs[3] = '{1,  4'h1, 32'h0000_4000, 1,  1};
    vecs[4] = '{2,  4'h7, 32'h8000_0005, 7,  2};
    vecs[5] = '{1,  4'hF, 32'hFFFF_FFFC, 4,  1};

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checkReset("reset");
`ifdef RX_STAGER_DROP_OVERSIZE_EN
    checkOutput("reset drop_count", drop_count, 0);
`endif
    @(posedge aclk); #1;
    aresetn = 1'b1;
    repeat (2) @(posedge aclk); #1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      waitStats(statCount + 1, $sformatf("vec%0d", i));
      checkFrames($sformatf("vec%0d", i));
    end

    // Three frames buffered while no host address is offered.
    bufEnable = 0;
    repeat (2) @(posedge aclk); #1;
    n = statCount;
    queueFrame(8, 32'h0001_0000);
    queueFrame(13, 32'h0002_0001);
    queueFrame(22, 32'h0003_0002);
    repeat (20) @(posedge aclk); #1;
    checkOutput("held cmd count", gotCmdQ.size(), 0);
    bufEnable = 1;
    waitStats(n + 3, "held");
    checkFrames("held");

    // A zero-byte frame is discarded; the following 4-byte frame is not.
    n = statCount;
    sendFrame(1, 4'h0, 1'b0);
    queueFrame(4, 32'h0000_0444);
    waitStats(n + 1, "zero");
    repeat (10) @(posedge aclk); #1;
    checkFrames("zero");

`ifdef RX_STAGER_DROP_OVERSIZE_EN
    n = statCount;
    sendFrame(400, 4'hF, 1'b0);
    queueFrame(100, 32'h0000_0100);
    waitStats(n + 1, "drop");
    checkOutput("drop_count", drop_count, 1);
    checkFrames("drop");
`endif

    // Random lengths with random cmd_ready / dout_tready stalls.
    stallMode = 1;
    n = statCount;
    for (int i = 0; i < 100; i++) queueFrame($urandom_range(1, 1522), $urandom());
    waitStats(n + 100, "random");
    stallMode = 0;
    repeat (3) @(posedge aclk); #1;
    checkFrames("random");

    // Reset in the middle of a data burst, then one clean frame.
    n = 0;
    expFrameQ.push_back('{32'h0000_0777, 64, 16, 4'hF});
    bufQ.push_back(32'h0000_0777);
    sendFrame(16, 4'hF, 1'b1);
    while (gotBeatQ.size() < 4 && n < 2000) begin
      @(posedge aclk); #1;
      n++;
    end
    if (gotBeatQ.size() < 4) failTimeout("mid-data beats");
    aresetn = 1'b0;
    @(negedge aclk);
    checkReset("mid-data reset");
    expFrameQ.delete(); expBeatQ.delete(); gotBeatQ.delete();
    gotCmdQ.delete(); gotStatQ.delete(); bufQ.delete();
    repeat (2) @(posedge aclk); #1;
    aresetn = 1'b1;
    repeat (2) @(posedge aclk); #1;
    n = statCount;
    queueFrame(4, 32'h0000_5004);
    waitStats(n + 1, "after reset");
    checkFrames("after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
